// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-requester byte-wide RAM arbiter.
// Optional build macro: MEM_ARBITER_RR_EN (round-robin arbitration).
package mem_arbiter_pkg;

    // Transfer length encodings; 2'b10 is treated like a word.
    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b11;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Index of the final byte of a transfer of the given length.
    function automatic logic [1:0] last_idx(input logic [1:0] len);
        case (len)
            LEN_B:   last_idx = 2'd0;
            LEN_H:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and RAM-side signals of the arbiter.
// The slave modport is the arbiter; the master modport is its surroundings
// (fetch stage, MEM stage and the RAM pins).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_flush_i;
    logic              if_done_o;
    logic [31:0]       if_data_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [1:0]        mem_len_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic              mem_done_o;
    logic [31:0]       mem_rdata_o;

    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_wr_o;
    logic [7:0]        ram_dout_o;
    logic [7:0]        ram_din_i;

    logic              busy_o;
    logic              owner_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_done_o, if_data_o,
        input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        output mem_done_o, mem_rdata_o,
        output ram_addr_o, ram_wr_o, ram_dout_o,
        input  ram_din_i,
        output busy_o, owner_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_done_o, if_data_o,
        output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        input  mem_done_o, mem_rdata_o,
        input  ram_addr_o, ram_wr_o, ram_dout_o,
        output ram_din_i,
        input  busy_o, owner_o
    );

endinterface

// File: rtl/mem_arb_seq.sv
// Byte sequencer: walks a 1/2/4-byte transfer one byte per cycle, drives the
// RAM address / write strobe / write data registers, and assembles read
// bytes little-endian. The RAM returns data one cycle after the address.
module mem_arb_seq
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base,
    input  logic [1:0]        len,
    input  logic              we,
    input  logic [31:0]       wdata,
    input  logic [7:0]        din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              wr,
    output logic [7:0]        dout,
    output logic [31:0]       data,
    output logic              last
);

    logic        active_q;
    logic [1:0]  cnt_q;
    logic [1:0]  last_idx_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        cap_en_q;
    logic [1:0]  cap_idx_q;
    logic [31:0] data_q;
    logic [31:0] data_d;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    byte_of = w[7:0];
            2'd1:    byte_of = w[15:8];
            2'd2:    byte_of = w[23:16];
            default: byte_of = w[31:24];
        endcase
    endfunction

    assign last = active_q && (cnt_q == last_idx_q);

    // Merge the byte arriving from the RAM this cycle into the assembled word.
    always_comb begin
        data_d = data_q;
        if (cap_en_q) begin
            case (cap_idx_q)
                2'd0:    data_d[7:0]   = din;
                2'd1:    data_d[15:8]  = din;
                2'd2:    data_d[23:16] = din;
                default: data_d[31:24] = din;
            endcase
        end
    end

    assign data = data_d;

    // Latch the transfer on start, then step address/data one byte per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= 1'b0;
            cnt_q      <= 2'd0;
            last_idx_q <= 2'd0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            cap_en_q   <= 1'b0;
            cap_idx_q  <= 2'd0;
            data_q     <= '0;
            ram_addr   <= '0;
            wr         <= 1'b0;
            dout       <= '0;
        end else if (start) begin
            active_q   <= 1'b1;
            cnt_q      <= 2'd0;
            last_idx_q <= last_idx(len);
            we_q       <= we;
            wdata_q    <= wdata;
            cap_en_q   <= 1'b0;
            cap_idx_q  <= 2'd0;
            data_q     <= '0;
            ram_addr   <= base;
            wr         <= we;
            dout       <= wdata[7:0];
        end else begin
            data_q    <= data_d;
            // A read address on the bus now yields its byte next cycle.
            cap_en_q  <= active_q && !we_q && !abort;
            cap_idx_q <= cnt_q;
            if (active_q && !abort && !last) begin
                cnt_q    <= cnt_q + 2'd1;
                ram_addr <= ram_addr + 1'b1;
                wr       <= we_q;
                dout     <= byte_of(wdata_q, cnt_q + 2'd1);
            end else begin
                active_q <= 1'b0;
                wr       <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one byte-wide RAM port between instruction fetch (IF) and
// the MEM stage. Fixed MEM-over-IF priority by default; define
// MEM_ARBITER_RR_EN for round-robin on simultaneous requests.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    state_e            state_q, state_d;
    owner_e            owner_q;
    owner_e            gnt_owner;
    logic              we_q;
    logic              mask_if_q;
    logic              mask_mem_q;
    logic [31:0]       if_data_q;
    logic [31:0]       mem_rdata_q;

    logic              start;
    logic              abort;
    logic              if_ok;
    logic              mem_ok;
    logic              sel_mem;
    logic [ADDR_W-1:0] sel_base;
    logic [1:0]        sel_len;
    logic              sel_we;
    logic [31:0]       sel_wdata;

    logic [ADDR_W-1:0] seq_addr;
    logic              seq_wr;
    logic [7:0]        seq_dout;
    logic [31:0]       seq_data;
    logic              seq_last;

    // A requester that just finished is masked for one IDLE cycle so its
    // not-yet-dropped request cannot re-grant; a flush vetoes IF in IDLE.
    assign if_ok  = bus.if_req_i && !bus.if_flush_i && !mask_if_q;
    assign mem_ok = bus.mem_req_i && !mask_mem_q;

    // Arbitration and transfer-phase sequencing.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        abort     = 1'b0;
        gnt_owner = owner_q;
        case (state_q)
            IDLE: begin
                if (mem_ok && if_ok) begin
                    start   = 1'b1;
                    state_d = XFER;
`ifdef MEM_ARBITER_RR_EN
                    gnt_owner = (owner_q == OWN_MEM) ? OWN_IF : OWN_MEM;
`else
                    gnt_owner = OWN_MEM;
`endif
                end else if (mem_ok) begin
                    start     = 1'b1;
                    state_d   = XFER;
                    gnt_owner = OWN_MEM;
                end else if (if_ok) begin
                    start     = 1'b1;
                    state_d   = XFER;
                    gnt_owner = OWN_IF;
                end
            end
            XFER: begin
                if (owner_q == OWN_IF && bus.if_flush_i) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (seq_last) begin
                    state_d = we_q ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (owner_q == OWN_IF && bus.if_flush_i) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Route the granted requester's transfer parameters to the sequencer.
    assign sel_mem   = (gnt_owner == OWN_MEM);
    assign sel_base  = sel_mem ? bus.mem_addr_i : bus.if_addr_i;
    assign sel_len   = sel_mem ? bus.mem_len_i : LEN_W;
    assign sel_we    = sel_mem && bus.mem_we_i;
    assign sel_wdata = sel_mem ? bus.mem_wdata_i : 32'd0;

    mem_arb_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .base     (sel_base),
        .len      (sel_len),
        .we       (sel_we),
        .wdata    (sel_wdata),
        .din      (bus.ram_din_i),
        .ram_addr (seq_addr),
        .wr       (seq_wr),
        .dout     (seq_dout),
        .data     (seq_data),
        .last     (seq_last)
    );

    // State, owner, post-done masks and per-requester read-data holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            we_q        <= 1'b0;
            mask_if_q   <= 1'b0;
            mask_mem_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            mask_if_q  <= (state_q == DONE) && (owner_q == OWN_IF);
            mask_mem_q <= (state_q == DONE) && (owner_q == OWN_MEM);
            if (start) begin
                owner_q <= gnt_owner;
                we_q    <= sel_we;
            end
            // The final read byte is merged combinationally while in DRAIN.
            if (state_q == DRAIN && state_d == DONE) begin
                if (owner_q == OWN_IF) begin
                    if_data_q <= seq_data;
                end else begin
                    mem_rdata_q <= seq_data;
                end
            end
        end
    end

    assign bus.if_done_o   = (state_q == DONE) && (owner_q == OWN_IF);
    assign bus.mem_done_o  = (state_q == DONE) && (owner_q == OWN_MEM);
    assign bus.if_data_o   = if_data_q;
    assign bus.mem_rdata_o = mem_rdata_q;
    assign bus.ram_addr_o  = seq_addr;
    assign bus.ram_wr_o    = seq_wr;
    assign bus.ram_dout_o  = seq_dout;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.owner_o     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a registered-read byte RAM model.
// Expectations follow MEM_ARBITER_RR_EN when it is defined.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic wr_seen;
    int   if_done_cyc;
    int   mem_done_cyc;
    logic [31:0] first_owner;

    logic [7:0] ram [0:65535];

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // RAM model: data for an address appears one cycle later; preloaded in reset.
    always @(posedge clk) begin
        if (rst) begin
            ram[16'h1000] <= 8'h13; ram[16'h1001] <= 8'h05;
            ram[16'h1002] <= 8'h00; ram[16'h1003] <= 8'h00;
            ram[16'h2000] <= 8'h93; ram[16'h2001] <= 8'h00;
            ram[16'h2002] <= 8'h10; ram[16'h2003] <= 8'h00;
            ram[16'h0030] <= 8'hA5; ram[16'h0031] <= 8'h77;
            ram[16'hFFFF] <= 8'h34; ram[16'h0000] <= 8'h12;
            ram[16'h0001] <= 8'hCC;
        end else if (bus.ram_wr_o) begin
            ram[bus.ram_addr_o[15:0]] <= bus.ram_dout_o;
        end
        bus.ram_din_i <= ram[bus.ram_addr_o[15:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        clk = 1'b0; rst = 1'b1;
        bus.if_req_i = 0; bus.if_addr_i = 0; bus.if_flush_i = 0;
        bus.mem_req_i = 0; bus.mem_we_i = 0; bus.mem_len_i = 0;
        bus.mem_addr_i = 0; bus.mem_wdata_i = 0;
        tick(); tick();
        check("rst_busy", bus.busy_o, 0);
        check("rst_owner", bus.owner_o, 0);
        check("rst_wr", bus.ram_wr_o, 0);
        check("rst_addr", bus.ram_addr_o, 0);
        check("rst_ifdone", bus.if_done_o, 0);
        check("rst_memdone", bus.mem_done_o, 0);
        rst = 1'b0;

        // IF fetch at 0x1000; req held through the first IDLE cycle
        tick();
        bus.if_req_i = 1; bus.if_addr_i = 32'h1000;
        wr_seen = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus.ram_wr_o) wr_seen = 1;
            check("if1_done", bus.if_done_o, (c == 6));
            if (c >= 1 && c <= 4) check("if1_addr", bus.ram_addr_o, 32'h1000 + c - 1);
            if (c == 1) check("if1_busy", bus.busy_o, 1);
            if (c == 6) check("if1_data", bus.if_data_o, 32'h00000513);
            if (c == 8) begin
                check("if1_noregrant", bus.busy_o, 0);
                bus.if_req_i = 0;
            end
        end
        check("if1_nowr", wr_seen, 0);

        // MEM word store at 0x20
        tick();
        bus.mem_req_i = 1; bus.mem_we_i = 1; bus.mem_len_i = 2'b11;
        bus.mem_addr_i = 32'h20; bus.mem_wdata_i = 32'hDEADBEEF;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check("st_wr", bus.ram_wr_o, (c >= 1 && c <= 4));
            check("st_done", bus.mem_done_o, (c == 5));
            if (c == 1) check("st_owner", bus.owner_o, 1);
            if (c == 1) begin check("st_a0", bus.ram_addr_o, 32'h20); check("st_d0", bus.ram_dout_o, 32'hEF); end
            if (c == 2) begin check("st_a1", bus.ram_addr_o, 32'h21); check("st_d1", bus.ram_dout_o, 32'hBE); end
            if (c == 3) begin check("st_a2", bus.ram_addr_o, 32'h22); check("st_d2", bus.ram_dout_o, 32'hAD); end
            if (c == 4) begin check("st_a3", bus.ram_addr_o, 32'h23); check("st_d3", bus.ram_dout_o, 32'hDE); end
            if (c == 7) begin
                check("st_idle", bus.busy_o, 0);
                bus.mem_req_i = 0; bus.mem_we_i = 0;
            end
        end
        check("st_ram", {ram[16'h23], ram[16'h22], ram[16'h21], ram[16'h20]}, 32'hDEADBEEF);

        // Simultaneous requests: MEM byte load at 0x30 and IF fetch at 0x1000
`ifdef MEM_ARBITER_RR_EN
        first_owner = 0; if_done_cyc = 6; mem_done_cyc = 10;
`else
        first_owner = 1; if_done_cyc = 10; mem_done_cyc = 3;
`endif
        tick();
        bus.mem_req_i = 1; bus.mem_we_i = 0; bus.mem_len_i = 2'b00; bus.mem_addr_i = 32'h30;
        bus.if_req_i = 1; bus.if_addr_i = 32'h1000;
        for (int c = 1; c <= 11; c++) begin
            tick();
            check("arb_ifdone", bus.if_done_o, (c == if_done_cyc));
            check("arb_memdone", bus.mem_done_o, (c == mem_done_cyc));
            if (c == 1) check("arb_owner", bus.owner_o, first_owner);
            if (c == mem_done_cyc) check("arb_memdata", bus.mem_rdata_o, 32'h000000A5);
            if (c == if_done_cyc) check("arb_ifdata", bus.if_data_o, 32'h00000513);
            if (c == mem_done_cyc + 2) check("arb_owner2", bus.owner_o, 0);
            if (c == if_done_cyc + 2) check("arb_owner2", bus.owner_o, 1);
            if (c == mem_done_cyc + 1) bus.mem_req_i = 0;
            if (c == if_done_cyc + 1) bus.if_req_i = 0;
            if (c == 11) check("arb_idle", bus.busy_o, 0);
        end

        // Flush an IF fetch in cycle 3, then refetch from 0x2000
        tick();
        bus.if_req_i = 1; bus.if_addr_i = 32'h1000;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("fl_nodone", bus.if_done_o, 0);
        end
        bus.if_flush_i = 1;
        tick();
        check("fl_busy", bus.busy_o, 0);
        check("fl_nodone4", bus.if_done_o, 0);
        check("fl_hold", bus.if_data_o, 32'h00000513);
        bus.if_addr_i = 32'h2000;
        tick();
        check("fl_idleblock", bus.busy_o, 0);
        bus.if_flush_i = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            check("fl2_done", bus.if_done_o, (c == 6));
            if (c == 6) check("fl2_data", bus.if_data_o, 32'h00100093);
            if (c == 7) bus.if_req_i = 0;
        end

        // Reset in cycle 2 of a MEM word store
        tick();
        bus.mem_req_i = 1; bus.mem_we_i = 1; bus.mem_len_i = 2'b11;
        bus.mem_addr_i = 32'h40; bus.mem_wdata_i = 32'h11223344;
        tick();
        check("rs_wr1", bus.ram_wr_o, 1);
        tick();
        rst = 1; bus.mem_req_i = 0; bus.mem_we_i = 0;
        tick();
        check("rs_busy", bus.busy_o, 0);
        check("rs_owner", bus.owner_o, 0);
        check("rs_wr", bus.ram_wr_o, 0);
        check("rs_addr", bus.ram_addr_o, 0);
        check("rs_dout", bus.ram_dout_o, 0);
        check("rs_memdone", bus.mem_done_o, 0);
        check("rs_ifdata", bus.if_data_o, 0);
        check("rs_memdata", bus.mem_rdata_o, 0);
        rst = 0;

        // Halfword load wrapping from 0xFFFFFFFF to 0x00000000
        bus.mem_req_i = 1; bus.mem_we_i = 0; bus.mem_len_i = 2'b01; bus.mem_addr_i = 32'hFFFFFFFF;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("hw_wr", bus.ram_wr_o, 0);
            check("hw_done", bus.mem_done_o, (c == 4));
            if (c == 1) check("hw_a0", bus.ram_addr_o, 32'hFFFFFFFF);
            if (c == 2) check("hw_a1", bus.ram_addr_o, 32'h00000000);
            if (c == 4) check("hw_data", bus.mem_rdata_o, 32'h00001234);
            if (c == 5) bus.mem_req_i = 0;
            if (c == 6) check("hw_idle", bus.busy_o, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between two requesters: instruction fetch (IF, read-only, 4 bytes) and the MEM stage (loads/stores of 1, 2 or 4 bytes).
- Sequences multi-byte transfers one byte per cycle and assembles read data little-endian.
- Returns a one-cycle done pulse per transfer and drives a busy flag for pipeline stall generation.
- Sits between the fetch stage / MEM stage and the top-level RAM pins.

Parameters:
- ADDR_W, 32, address width of requesters and RAM.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req_i  in  1  IF read request; held until if_done_o
- if_addr_i  in  ADDR_W  IF word address (byte-addressed)
- if_flush_i  in  1  abort the in-flight IF transfer (branch redirect)
- if_done_o  out  1  one-cycle pulse: if_data_o valid
- if_data_o  out  32  assembled instruction
- mem_req_i  in  1  MEM request; held until mem_done_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_len_i  in  2  00 = 1 B, 01 = 2 B, 11 = 4 B (10 treated as 4 B)
- mem_addr_i  in  ADDR_W  MEM byte address
- mem_wdata_i  in  32  store data
- mem_done_o  out  1  one-cycle pulse: transfer complete, mem_rdata_o valid for loads
- mem_rdata_o  out  32  load data, zero-filled above len
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_wr_o  out  1  RAM write strobe
- ram_dout_o  out  8  RAM write data
- ram_din_i  in  8  RAM read data, valid the cycle after ram_addr_o is presented
- busy_o  out  1  high whenever state is not IDLE
- owner_o  out  1  0 = IF, 1 = MEM; meaningful while busy_o

Behaviour:
- Reset (synchronous, active-high): state IDLE; all outputs 0; byte counter 0; latched request cleared. Reset mid-transfer abandons it silently, with no done pulse.
- States:
  - IDLE: arbitrate and latch.
  - XFER: issue addresses, counter k = 0..n-1.
  - DRAIN: reads only, capture the final byte.
  - DONE: pulse done, return to IDLE.
- Grant and latch:
  - IDLE samples requests at cycle 0 and latches addr, len, we and wdata.
  - Registers ram_addr_o = addr for byte 0, then goes to XFER.
- Arbitration: fixed priority, MEM over IF. If both requests are high in IDLE, MEM is granted and IF waits.
- Address sequencing: byte k address = base + k, visible in cycle k+1.
- Reads: byte k is captured from ram_din_i in cycle k+2 into data[8k+7:8k].
- Writes:
  - ram_wr_o = 1 and ram_dout_o = wdata[8k+7:8k] in cycle k+1.
  - ram_wr_o is 0 in every other cycle.
- Latency from grant cycle 0:
  - Read of n bytes: done pulse in cycle n+2 (4 B fetch = cycle 6).
  - Write of n bytes: done pulse in cycle n+1, with no DRAIN.
- Done and hand-back:
  - The done pulse occurs in the DONE cycle; the arbiter is back in IDLE the following cycle.
  - The requester deasserts req in the cycle after done.
  - The finishing requester's req is ignored in the first IDLE cycle, so a stale req cannot re-grant.
- Data outputs: if_data_o and mem_rdata_o hold their value until the next done to the same requester.
- if_flush_i:
  - While IF owns the bus: the transfer is aborted, no if_done_o, and the arbiter returns to IDLE next cycle.
  - While MEM owns the bus: no effect.
  - In IDLE: IF's request is not granted that cycle.
- Address arithmetic wraps modulo 2^ADDR_W.
- Len 01 read: mem_rdata_o[31:16] = 0. Sign extension belongs to the MEM stage.

Optional Feature:
- Macro: MEM_ARBITER_RR_EN.
- Defined: round-robin arbitration. On a simultaneous request, the requester that did not own the previous transfer wins; after reset, MEM wins first.
- Undefined: fixed MEM-over-IF priority, as described above.

Decomposition:
- Shared package/defines:
  - Len encodings LEN_B, LEN_H, LEN_W.
  - Owner encodings OWN_IF, OWN_MEM.
  - State encodings IDLE, XFER, DRAIN, DONE.
- One sub-module, mem_arb_seq: byte counter, address increment and read-byte assembly. It takes base, len and we; it produces ram_addr, wr, dout, data and last. Arbitration and done routing stay in the top module.

Test Plan:
- IF read at 0x1000, RAM bytes 13 05 00 00 -> if_done_o in cycle 6, if_data_o = 0x00000513, ram_wr_o never high.
- MEM store, len 11, addr 0x20, wdata 0xDEADBEEF -> ram_wr_o high in cycles 1-4 with addr 0x20..0x23 and dout EF BE AD DE; mem_done_o in cycle 5.
- IF and MEM requests both high in the same cycle (MEM load, len 00) -> MEM granted, owner_o = 1; IF granted in the IDLE cycle after MEM's done. Under MEM_ARBITER_RR_EN with a previous MEM owner -> IF granted first.
- if_flush_i asserted in cycle 3 of an IF fetch -> no if_done_o, busy_o low in cycle 4, a new IF request at 0x2000 completes correctly.
- rst asserted in cycle 2 of a MEM 4 B write -> all outputs 0 next cycle, no mem_done_o, ram_wr_o low, a subsequent request serviced normally.
- MEM load, len 01, addr 0xFFFFFFFF -> second byte read from 0x00000000, mem_rdata_o[31:16] = 0.
